// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states: idle, serving fetch, serving data, draining a flushed request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // Identifies which requester wins an arbitration round.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Fetches are always 4-byte reads.
    localparam logic [2:0] MSIZE4 = 3'd2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data and downstream memory bus signals around the arbiter.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok;
    logic              iresp_data_ok;
    logic [31:0]       iresp_data;

    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_data;
    logic                dresp_addr_ok;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;

    logic                mreq_valid;
    logic [ADDR_W-1:0]   mreq_addr;
    logic [2:0]          mreq_size;
    logic [DATA_W/8-1:0] mreq_strobe;
    logic [DATA_W-1:0]   mreq_data;
    logic                mresp_addr_ok;
    logic                mresp_data_ok;
    logic [DATA_W-1:0]   mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        input  mresp_addr_ok, mresp_data_ok, mresp_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        output mresp_addr_ok, mresp_data_ok, mresp_data
    );
endinterface

// File: rtl/mem_bus_arbiter_arb_fair_counter.sv
// Starvation counter: counts dbus grants issued while a fetch is waiting,
// saturating at 7, cleared whenever the fetch port is granted.
module arb_fair_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dgrant_i,
    input  logic igrant_i,
    input  logic ireq_valid_i,
    output logic starved_o
);
    logic [2:0] count_q;

    // Count dbus wins over a waiting fetch; any fetch grant restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 3'd0;
        end else if (igrant_i) begin
            count_q <= 3'd0;
        end else if (dgrant_i && ireq_valid_i && (count_q != 3'd7)) begin
            count_q <= count_q + 3'd1;
        end
    end

    assign starved_o = (count_q == 3'(STARVE_MAX));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one downstream memory bus between fetch (ibus) and data (dbus).
// The winner's request is latched into registered mreq_* fields; the single-beat
// response is routed back only to the current owner. A one-cycle IDLE bubble
// separates consecutive grants.
// Optional macro ARB_FAIRNESS_EN: lets ibus win after STARVE_MAX consecutive dbus
// grants taken while ibus was waiting; otherwise dbus has strict priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
`ifdef ARB_FAIRNESS_EN
    , parameter int STARVE_MAX = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    mem_bus_arbiter_if.slave bus
);
    arb_state_t          state_q;
    logic                mreq_valid_q;
    logic [ADDR_W-1:0]   mreq_addr_q;
    logic [2:0]          mreq_size_q;
    logic [DATA_W/8-1:0] mreq_strobe_q;
    logic [DATA_W-1:0]   mreq_data_q;

    logic   ibus_pref;
    logic   grant_i;
    logic   grant_d;
    owner_t winner;

`ifdef ARB_FAIRNESS_EN
    logic starved;

    arb_fair_counter #(.STARVE_MAX(STARVE_MAX)) u_fair (
        .clk          (clk),
        .rst          (rst),
        .dgrant_i     (grant_d),
        .igrant_i     (grant_i),
        .ireq_valid_i (bus.ireq_valid),
        .starved_o    (starved)
    );

    assign ibus_pref = starved && bus.ireq_valid && bus.dreq_valid;
`else
    assign ibus_pref = 1'b0;
`endif

    // Arbitration in IDLE: dbus first unless the fetch side has been starved.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.dreq_valid && !ibus_pref) begin
                grant_d = 1'b1;
            end else if (bus.ireq_valid) begin
                grant_i = 1'b1;
            end
        end
        winner = grant_d ? OWN_D : OWN_I;
    end

    // Arbiter FSM and downstream request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mreq_valid_q  <= 1'b0;
            mreq_addr_q   <= '0;
            mreq_size_q   <= 3'd0;
            mreq_strobe_q <= '0;
            mreq_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        mreq_valid_q <= 1'b1;
                        if (winner == OWN_D) begin
                            state_q       <= BUSY_D;
                            mreq_addr_q   <= bus.dreq_addr;
                            mreq_size_q   <= bus.dreq_size;
                            mreq_strobe_q <= bus.dreq_strobe;
                            mreq_data_q   <= bus.dreq_data;
                        end else begin
                            state_q       <= BUSY_I;
                            mreq_addr_q   <= bus.ireq_addr;
                            mreq_size_q   <= MSIZE4;
                            mreq_strobe_q <= '0;
                            mreq_data_q   <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (bus.mresp_data_ok) begin
                        state_q      <= IDLE;
                        mreq_valid_q <= 1'b0;
                    end else if (!bus.ireq_valid) begin
                        state_q <= DRAIN;
                    end
                end
                BUSY_D: begin
                    if (bus.mresp_data_ok) begin
                        state_q      <= IDLE;
                        mreq_valid_q <= 1'b0;
                    end else if (!bus.dreq_valid) begin
                        state_q <= DRAIN;
                    end
                end
                default: begin
                    // DRAIN: wait out the abandoned request, deliver nothing.
                    if (bus.mresp_data_ok) begin
                        state_q      <= IDLE;
                        mreq_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.mreq_valid  = mreq_valid_q;
    assign bus.mreq_addr   = mreq_addr_q;
    assign bus.mreq_size   = mreq_size_q;
    assign bus.mreq_strobe = mreq_strobe_q;
    assign bus.mreq_data   = mreq_data_q;

    // Route downstream responses to the current owner only.
    always_comb begin
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = 32'd0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = '0;
        if (state_q == BUSY_I) begin
            bus.iresp_addr_ok = bus.mresp_addr_ok;
            bus.iresp_data_ok = bus.mresp_data_ok;
            if (bus.mresp_data_ok) begin
                bus.iresp_data = mreq_addr_q[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0];
            end
        end else if (state_q == BUSY_D) begin
            bus.dresp_addr_ok = bus.mresp_addr_ok;
            bus.dresp_data_ok = bus.mresp_data_ok;
            if (bus.mresp_data_ok) begin
                bus.dresp_data = bus.mresp_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: reset, fetch, priority, flush,
// mid-operation reset, fairness and write passthrough scenarios.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL reset_mreq_valid got %0b want 0", bus.mreq_valid); end
        checks++; if (bus.mreq_addr !== 64'd0) begin errors++; $display("FAIL reset_mreq_addr got %h want 0", bus.mreq_addr); end
        checks++; if (bus.mreq_size !== 3'd0 || bus.mreq_strobe !== 8'd0 || bus.mreq_data !== 64'd0) begin errors++; $display("FAIL reset_mreq_fields got size %0d strobe %h data %h want 0", bus.mreq_size, bus.mreq_strobe, bus.mreq_data); end
        checks++; if (bus.iresp_data_ok !== 1'b0 || bus.dresp_data_ok !== 1'b0) begin errors++; $display("FAIL reset_resp got i %0b d %0b want 0", bus.iresp_data_ok, bus.dresp_data_ok); end
        $display("txn reset done");
    endtask

    task automatic test_fetch();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0004;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL fetch_pre_valid got %0b want 0", bus.mreq_valid); end
        tick();
        checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0004) begin errors++; $display("FAIL fetch_issue got valid %0b addr %h want 1 80000004", bus.mreq_valid, bus.mreq_addr); end
        checks++; if (bus.mreq_size !== 3'd2 || bus.mreq_strobe !== 8'h00 || bus.mreq_data !== 64'd0) begin errors++; $display("FAIL fetch_fields got size %0d strobe %h data %h want 2 00 0", bus.mreq_size, bus.mreq_strobe, bus.mreq_data); end
        bus.mresp_addr_ok = 1'b1;
        #1;
        checks++; if (bus.iresp_addr_ok !== 1'b1 || bus.dresp_addr_ok !== 1'b0) begin errors++; $display("FAIL fetch_addr_ok got i %0b d %0b want 1 0", bus.iresp_addr_ok, bus.dresp_addr_ok); end
        tick();
        bus.mresp_addr_ok = 1'b0;
        bus.mresp_data_ok = 1'b1;
        bus.mresp_data    = 64'h1111_2222_3333_4444;
        bus.ireq_valid    = 1'b0;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'h1111_2222) begin errors++; $display("FAIL fetch_data got ok %0b data %h want 1 11112222", bus.iresp_data_ok, bus.iresp_data); end
        checks++; if (bus.dresp_data_ok !== 1'b0 || bus.dresp_data !== 64'd0) begin errors++; $display("FAIL fetch_dresp_quiet got ok %0b data %h want 0 0", bus.dresp_data_ok, bus.dresp_data); end
        tick();
        bus.mresp_data_ok = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0 || bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL fetch_done got valid %0b ok %0b want 0 0", bus.mreq_valid, bus.iresp_data_ok); end
        $display("txn fetch addr 80000004 data %h", 32'h1111_2222);
    endtask

    task automatic test_priority();
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h8000_0000;
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h8000_1000;
        bus.dreq_size   = 3'd3;
        bus.dreq_strobe = 8'hFF;
        bus.dreq_data   = 64'h0123_4567_89AB_CDEF;
        tick();
        checks++; if (bus.mreq_addr !== 64'h8000_1000 || bus.mreq_strobe !== 8'hFF) begin errors++; $display("FAIL prio_dbus_first got addr %h strobe %h want 80001000 ff", bus.mreq_addr, bus.mreq_strobe); end
        bus.mresp_data_ok = 1'b1;
        bus.mresp_data    = 64'h5555_6666_7777_8888;
        bus.dreq_valid    = 1'b0;
        #1;
        checks++; if (bus.dresp_data_ok !== 1'b1 || bus.dresp_data !== 64'h5555_6666_7777_8888 || bus.iresp_data_ok !== 1'b0) begin errors++; $display("FAIL prio_dresp got ok %0b data %h iok %0b want 1 5555666677778888 0", bus.dresp_data_ok, bus.dresp_data, bus.iresp_data_ok); end
        tick();
        bus.mresp_data_ok = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL prio_bubble got valid %0b want 0", bus.mreq_valid); end
        tick();
        checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0000 || bus.mreq_size !== 3'd2 || bus.mreq_strobe !== 8'h00) begin errors++; $display("FAIL prio_ibus_next got valid %0b addr %h size %0d strobe %h want 1 80000000 2 00", bus.mreq_valid, bus.mreq_addr, bus.mreq_size, bus.mreq_strobe); end
        bus.mresp_data_ok = 1'b1;
        bus.mresp_data    = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.ireq_valid    = 1'b0;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b1 || bus.iresp_data !== 32'hCCCC_DDDD) begin errors++; $display("FAIL prio_idata got ok %0b data %h want 1 ccccdddd", bus.iresp_data_ok, bus.iresp_data); end
        tick();
        bus.mresp_data_ok = 1'b0;
        $display("txn priority dbus then ibus");
    endtask

    task automatic test_flush();
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h8000_3000;
        bus.dreq_size   = 3'd3;
        bus.dreq_strobe = 8'h00;
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h8000_0040;
        tick();
        bus.dreq_valid = 1'b0;
        tick();
        checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_3000) begin errors++; $display("FAIL flush_hold got valid %0b addr %h want 1 80003000", bus.mreq_valid, bus.mreq_addr); end
        bus.mresp_data_ok = 1'b1;
        bus.mresp_data    = 64'h9999_9999_9999_9999;
        #1;
        checks++; if (bus.dresp_data_ok !== 1'b0 || bus.iresp_data_ok !== 1'b0 || bus.dresp_data !== 64'd0) begin errors++; $display("FAIL flush_suppress got dok %0b iok %0b ddata %h want 0 0 0", bus.dresp_data_ok, bus.iresp_data_ok, bus.dresp_data); end
        tick();
        bus.mresp_data_ok = 1'b0;
        tick();
        checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== 64'h8000_0040) begin errors++; $display("FAIL flush_next_ibus got valid %0b addr %h want 1 80000040", bus.mreq_valid, bus.mreq_addr); end
        bus.mresp_data_ok = 1'b1;
        bus.ireq_valid    = 1'b0;
        tick();
        bus.mresp_data_ok = 1'b0;
        $display("txn flush dbus drained, ibus granted");
    endtask

    task automatic test_reset_midop();
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h8000_0100;
        tick();
        checks++; if (bus.mreq_valid !== 1'b1) begin errors++; $display("FAIL midrst_busy got valid %0b want 1", bus.mreq_valid); end
        bus.ireq_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0 || bus.mreq_addr !== 64'd0) begin errors++; $display("FAIL midrst_clear got valid %0b addr %h want 0 0", bus.mreq_valid, bus.mreq_addr); end
        bus.mresp_data_ok = 1'b1;
        bus.mresp_data    = 64'h1234_5678_1234_5678;
        #1;
        checks++; if (bus.iresp_data_ok !== 1'b0 || bus.iresp_data !== 32'd0) begin errors++; $display("FAIL midrst_stray got ok %0b data %h want 0 0", bus.iresp_data_ok, bus.iresp_data); end
        tick();
        bus.mresp_data_ok = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got valid %0b want 0", bus.mreq_valid); end
        $display("txn reset mid-operation");
    endtask

    task automatic test_fairness();
        logic [63:0] exp_addr;
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h8000_4000;
        bus.dreq_size   = 3'd3;
        bus.dreq_strobe = 8'h00;
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h8000_0080;
        for (int k = 0; k < 5; k++) begin
            tick();
`ifdef ARB_FAIRNESS_EN
            exp_addr = (k == 4) ? 64'h8000_0080 : 64'h8000_4000;
`else
            exp_addr = 64'h8000_4000;
`endif
            checks++; if (bus.mreq_valid !== 1'b1 || bus.mreq_addr !== exp_addr) begin errors++; $display("FAIL fair_grant%0d got valid %0b addr %h want 1 %h", k, bus.mreq_valid, bus.mreq_addr, exp_addr); end
            bus.mresp_data_ok = 1'b1;
            if (exp_addr == 64'h8000_0080) bus.ireq_valid = 1'b0;
            tick();
            bus.mresp_data_ok = 1'b0;
            $display("txn fairness round %0d granted addr %h", k, exp_addr);
        end
        bus.dreq_valid = 1'b0;
        bus.ireq_valid = 1'b0;
        tick();
    endtask

    task automatic test_write();
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h8000_2008;
        bus.dreq_size   = 3'd2;
        bus.dreq_strobe = 8'h0F;
        bus.dreq_data   = 64'h0000_0000_DEAD_BEEF;
        tick();
        checks++; if (bus.mreq_addr !== 64'h8000_2008 || bus.mreq_size !== 3'd2) begin errors++; $display("FAIL write_addr_size got %h %0d want 80002008 2", bus.mreq_addr, bus.mreq_size); end
        checks++; if (bus.mreq_strobe !== 8'h0F || bus.mreq_data !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL write_strobe_data got %h %h want 0f 00000000deadbeef", bus.mreq_strobe, bus.mreq_data); end
        bus.mresp_addr_ok = 1'b1;
        #1;
        checks++; if (bus.dresp_addr_ok !== 1'b1 || bus.iresp_addr_ok !== 1'b0) begin errors++; $display("FAIL write_addr_ok got d %0b i %0b want 1 0", bus.dresp_addr_ok, bus.iresp_addr_ok); end
        tick();
        bus.mresp_addr_ok = 1'b0;
        bus.mresp_data_ok = 1'b1;
        bus.dreq_valid    = 1'b0;
        tick();
        bus.mresp_data_ok = 1'b0;
        #1;
        checks++; if (bus.mreq_valid !== 1'b0) begin errors++; $display("FAIL write_done got valid %0b want 0", bus.mreq_valid); end
        $display("txn write addr 80002008 strobe 0f");
    endtask

    initial begin
        bus.ireq_valid    = 1'b0;
        bus.ireq_addr     = '0;
        bus.dreq_valid    = 1'b0;
        bus.dreq_addr     = '0;
        bus.dreq_size     = 3'd0;
        bus.dreq_strobe   = '0;
        bus.dreq_data     = '0;
        bus.mresp_addr_ok = 1'b0;
        bus.mresp_data_ok = 1'b0;
        bus.mresp_data    = '0;
        #1;
        test_reset();
        test_fetch();
        test_priority();
        test_flush();
        test_reset_midop();
        test_fairness();
        test_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
